// File: rtl/wam_pkg.sv
// wam_pkg: shared types and constants for the whack-a-mole game.
// Used by hit_scorer and btn_sync_edge.
package wam_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } game_state_t;

    localparam int NUM_HOLES = 9;
    localparam int LIVES_W   = 3;
    localparam int LIVES_DEF = 3;

endpackage

// File: rtl/hit_scorer_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer plus rising-edge detector.
// press_o is high for one cycle per synchronized button rise.
module btn_sync_edge
    import wam_pkg::*;
#(
    parameter int W = NUM_HOLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] press_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;
    logic [W-1:0] s2_dly_q;

    // Synchronizer chain plus one delayed copy for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            s2_dly_q <= '0;
        end else begin
            s1_q     <= btn_i;
            s2_q     <= s1_q;
            s2_dly_q <= s2_q;
        end
    end

    assign press_o = s2_q & ~s2_dly_q;

endmodule

// File: rtl/hit_scorer.sv
// hit_scorer: judges lit-mole windows as hits or misses, keeps score,
// misses and lives, and owns the idle/play/over game state.
// Optional macro WAM_WRONG_PENALTY_EN: wrong presses cost a miss and a life.
module hit_scorer #(
    parameter int SCORE_W   = 8,
    parameter int LIVES     = wam_pkg::LIVES_DEF,
    parameter int NUM_HOLES = wam_pkg::NUM_HOLES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_HOLES-1:0]        lights,
    input  logic [NUM_HOLES-1:0]        buttons,
    output logic                        playing,
    output logic                        game_over,
    output logic [SCORE_W-1:0]          score,
    output logic [SCORE_W-1:0]          misses,
    output logic [wam_pkg::LIVES_W-1:0] lives_left,
    output logic                        hit_pulse,
    output logic                        miss_pulse
);

    import wam_pkg::*;

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    game_state_t          state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   misses_q, misses_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 hit_done_q, hit_done_d;
    logic                 hit_pulse_q, hit_pulse_d;
    logic                 miss_pulse_q, miss_pulse_d;
    logic                 playing_q, playing_d;
    logic                 game_over_q, game_over_d;
    logic [NUM_HOLES-1:0] lights_q;
    logic [NUM_HOLES-1:0] press;

    logic win_close;
    logic win_open;
    logic hit;
    logic miss_close;
    logic charge;

    btn_sync_edge #(
        .W(NUM_HOLES)
    ) u_btn (
        .clk    (clk),
        .rst    (reset),
        .btn_i  (buttons),
        .press_o(press)
    );

    // Window events, hit/miss judgement and next-state logic.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        misses_d     = misses_q;
        lives_d      = lives_q;
        hit_done_d   = hit_done_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        win_close = (lights_q != '0) && (lights != lights_q);
        win_open  = (lights != '0) && (lights != lights_q);

        // A freshly opened window is hittable even if the previous one was hit.
        hit = (state_q == PLAY) && ((press & lights) != '0)
              && (win_open || !hit_done_q);
        miss_close = (state_q == PLAY) && win_close && !hit_done_q && !hit;
`ifdef WAM_WRONG_PENALTY_EN
        charge = miss_close
                 || ((state_q == PLAY) && ((press & ~lights) != '0) && !hit);
`else
        charge = miss_close;
`endif

        unique case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    misses_d   = '0;
                    lives_d    = LIVES_INIT;
                    hit_done_d = 1'b0;
                end
            end
            PLAY: begin
                if (hit) begin
                    hit_done_d  = 1'b1;
                    hit_pulse_d = 1'b1;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if (win_open) begin
                    hit_done_d = 1'b0;
                end
                if (charge) begin
                    miss_pulse_d = 1'b1;
                    lives_d      = lives_q - LIVES_W'(1);
                    if (misses_q != SCORE_MAX) begin
                        misses_d = misses_q + SCORE_W'(1);
                    end
                    if (lives_q == LIVES_W'(1)) begin
                        state_d = OVER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        playing_d   = (state_d == PLAY);
        game_over_d = (state_d == OVER);
    end

    // State, counters, pulses and the registered lights copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            score_q      <= '0;
            misses_q     <= '0;
            lives_q      <= LIVES_INIT;
            hit_done_q   <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
            lights_q     <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            lives_q      <= lives_d;
            hit_done_q   <= hit_done_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
            lights_q     <= lights;
        end
    end

    assign playing    = playing_q;
    assign game_over  = game_over_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign lives_left = lives_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_hit_scorer.sv
// tb_hit_scorer: directed scoreboard bench for hit_scorer.
// Honours WAM_WRONG_PENALTY_EN for the wrong-press step.
module tb_hit_scorer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [8:0] lights;
    logic [8:0] buttons;
    logic       playing;
    logic       game_over;
    logic [7:0] score;
    logic [7:0] misses;
    logic [2:0] lives_left;
    logic       hit_pulse;
    logic       miss_pulse;

    typedef struct {
        string      tag;
        logic [7:0] sc;
        logic [7:0] mi;
        logic [2:0] li;
        logic       pl;
        logic       ov;
        logic       hp;
        logic       mp;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   hp_cnt = 0;
    int   hp_base = 0;

    hit_scorer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lights    (lights),
        .buttons   (buttons),
        .playing   (playing),
        .game_over (game_over),
        .score     (score),
        .misses    (misses),
        .lives_left(lives_left),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (hit_pulse === 1'b1) hp_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        ncmp++;
        assert (got === want) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic exp_push(input string tag, input int sc, input int mi,
                            input int li, input bit pl, input bit ov,
                            input bit hp, input bit mp);
        exp_t e;
        e.tag = tag;
        e.sc  = 8'(sc);
        e.mi  = 8'(mi);
        e.li  = 3'(li);
        e.pl  = pl;
        e.ov  = ov;
        e.hp  = hp;
        e.mp  = mp;
        sb.push_back(e);
    endtask

    task automatic chk();
        exp_t e;
        if (sb.size() == 0) begin
            ncmp++;
            nfail++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".score"}, 32'(score), 32'(e.sc));
            cmp({e.tag, ".misses"}, 32'(misses), 32'(e.mi));
            cmp({e.tag, ".lives"}, 32'(lives_left), 32'(e.li));
            cmp({e.tag, ".playing"}, 32'(playing), 32'(e.pl));
            cmp({e.tag, ".game_over"}, 32'(game_over), 32'(e.ov));
            cmp({e.tag, ".hit_pulse"}, 32'(hit_pulse), 32'(e.hp));
            cmp({e.tag, ".miss_pulse"}, 32'(miss_pulse), 32'(e.mp));
        end
    endtask

    task automatic window(input logic [8:0] pat, input int len);
        lights = pat;
        tick(len);
        lights = '0;
        tick(1);
    endtask

    task automatic hit_window();
        lights = 9'h010;
        tick(1);
        buttons[4] = 1'b1;
        tick(3);
        buttons = '0;
        lights  = '0;
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        lights = '0;
        buttons = '0;
        tick(2);
        exp_push("rst", 0, 0, 3, 0, 0, 0, 0);
        chk();
        reset = 1'b0;
        tick(1);

        start = 1'b1;
        exp_push("start", 0, 0, 3, 1, 0, 0, 0);
        tick(1);
        start = 1'b0;
        chk();

        lights = 9'h010;
        tick(4);
        buttons[4] = 1'b1;
        exp_push("t1_lat", 0, 0, 3, 1, 0, 0, 0);
        tick(2);
        chk();
        exp_push("t1_hit", 1, 0, 3, 1, 0, 1, 0);
        tick(1);
        chk();
        exp_push("t1_after", 1, 0, 3, 1, 0, 0, 0);
        tick(1);
        chk();
        buttons = '0;
        tick(12);
        lights = '0;
        exp_push("t1_close", 1, 0, 3, 1, 0, 0, 0);
        tick(1);
        chk();

        lights = 9'h004;
        tick(10);
        lights = '0;
        exp_push("t2_close", 1, 1, 2, 1, 0, 0, 1);
        tick(1);
        chk();
        exp_push("t2_after", 1, 1, 2, 1, 0, 0, 0);
        tick(1);
        chk();

        exp_push("drain1", 1, 2, 1, 1, 0, 0, 1);
        window(9'h040, 3);
        chk();
        exp_push("drain2", 1, 3, 0, 0, 1, 0, 1);
        window(9'h080, 3);
        chk();

        start = 1'b1;
        exp_push("restart1", 0, 0, 3, 1, 0, 0, 0);
        tick(1);
        start = 1'b0;
        chk();

        exp_push("t3_w1", 0, 1, 2, 1, 0, 0, 1);
        window(9'h001, 4);
        chk();
        exp_push("t3_w2", 0, 2, 1, 1, 0, 0, 1);
        window(9'h002, 4);
        chk();
        exp_push("t3_w3", 0, 3, 0, 0, 1, 0, 1);
        window(9'h008, 4);
        chk();

        lights = 9'h010;
        buttons[4] = 1'b1;
        tick(5);
        buttons = '0;
        lights = '0;
        tick(3);
        exp_push("t3_frozen", 0, 3, 0, 0, 1, 0, 0);
        chk();

        start = 1'b1;
        exp_push("t3_restart", 0, 0, 3, 1, 0, 0, 0);
        tick(1);
        start = 1'b0;
        chk();

        lights = 9'h010;
        tick(2);
        buttons[4] = 1'b1;
        exp_push("t4_hit", 1, 0, 3, 1, 0, 1, 0);
        tick(3);
        chk();
        buttons = '0;
        tick(3);
        buttons[4] = 1'b1;
        exp_push("t4_second", 1, 0, 3, 1, 0, 0, 0);
        tick(3);
        chk();
        buttons = '0;
        lights = 9'h100;
        exp_push("t4_swap", 1, 0, 3, 1, 0, 0, 0);
        tick(1);
        chk();
        tick(5);
        lights = '0;
        exp_push("t4_close", 1, 1, 2, 1, 0, 0, 1);
        tick(1);
        chk();
        tick(2);

        hp_base = hp_cnt;
        for (int i = 0; i < 254; i++) hit_window();
        exp_push("t5_sat", 255, 1, 2, 1, 0, 0, 0);
        chk();
        cmp("t5_pulses", 32'(hp_cnt - hp_base), 32'd254);

        lights = 9'h010;
        tick(1);
        buttons[4] = 1'b1;
        exp_push("t5_hold", 255, 1, 2, 1, 0, 1, 0);
        tick(3);
        chk();
        buttons = '0;

        #3;
        reset = 1'b1;
        #1;
        exp_push("t5_arst", 0, 0, 3, 0, 0, 0, 0);
        chk();
        lights = '0;
        tick(2);
        reset = 1'b0;
        tick(1);

        start = 1'b1;
        exp_push("t6_start", 0, 0, 3, 1, 0, 0, 0);
        tick(1);
        start = 1'b0;
        chk();
        lights = 9'h001;
        tick(2);
        buttons[3] = 1'b1;
`ifdef WAM_WRONG_PENALTY_EN
        exp_push("t6_wrong", 0, 1, 2, 1, 0, 0, 1);
`else
        exp_push("t6_wrong", 0, 0, 3, 1, 0, 0, 0);
`endif
        tick(3);
        chk();
        buttons = '0;
        lights = '0;
        tick(2);

        cmp("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
